// File: rtl/cvxif_mac4b_ctrl_if.sv
// Bundle of the CV-X-IF issue/commit/result channels and the MAC4B datapath
// handshake seen by cvxif_mac4b_ctrl. The slave modport is the controller's view.
interface cvxif_mac4b_ctrl_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ID_WIDTH = 4
);
    // Issue channel
    logic                  issue_valid_i;
    logic                  issue_ready_o;
    logic [31:0]           issue_instr_i;
    logic [ID_WIDTH-1:0]   issue_id_i;
    logic [3*XLEN-1:0]     issue_rs_i;
    logic [2:0]            issue_rs_valid_i;
    logic                  issue_accept_o;
    logic                  issue_writeback_o;
    // Commit channel
    logic                  commit_valid_i;
    logic [ID_WIDTH-1:0]   commit_id_i;
    logic                  commit_kill_i;
    // Datapath
    logic                  mac_start_o;
    logic [XLEN-1:0]       mac_rs1_o;
    logic [XLEN-1:0]       mac_rs2_o;
    logic [XLEN-1:0]       mac_rs3_o;
    logic                  mac_done_i;
    logic [XLEN-1:0]       mac_result_i;
    // Result channel
    logic                  result_valid_o;
    logic                  result_ready_i;
    logic [ID_WIDTH-1:0]   result_id_o;
    logic [4:0]            result_rd_o;
    logic [XLEN-1:0]       result_data_o;
    logic                  result_we_o;

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
        output issue_ready_o, issue_accept_o, issue_writeback_o,
        input  commit_valid_i, commit_id_i, commit_kill_i,
        output mac_start_o, mac_rs1_o, mac_rs2_o, mac_rs3_o,
        input  mac_done_i, mac_result_i,
        output result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o,
        input  result_ready_i
    );

    modport master (
        output issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
        input  issue_ready_o, issue_accept_o, issue_writeback_o,
        output commit_valid_i, commit_id_i, commit_kill_i,
        input  mac_start_o, mac_rs1_o, mac_rs2_o, mac_rs3_o,
        output mac_done_i, mac_result_i,
        input  result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o,
        output result_ready_i
    );
endinterface

// File: rtl/cvxif_mac4b_ctrl.sv
// Issue/commit/result controller for the MAC4B coprocessor. Accepted instructions are
// queued in order; the head entry is run on the datapath once committed, and its
// result is offered on the backpressured result channel. Killed entries are dropped.
module cvxif_mac4b_ctrl #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ID_WIDTH = 4,
    parameter int unsigned DEPTH    = 4
) (
    input logic                clk_i,
    input logic                rst_ni,
    cvxif_mac4b_ctrl_if.slave  bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    logic [ID_WIDTH-1:0] id_q  [DEPTH];
    logic [4:0]          rd_q  [DEPTH];
    logic [XLEN-1:0]     rs1_q [DEPTH];
    logic [XLEN-1:0]     rs2_q [DEPTH];
    logic [XLEN-1:0]     rs3_q [DEPTH];
    logic [DEPTH-1:0]    valid_q, committed_q, killed_q;
    logic [PtrW-1:0]     head_q, tail_q;
    logic [CntW-1:0]     count_q;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     data_q, data_d;

    logic match, push, pop, start, push_hit;
    logic head_valid, head_committed, head_killed;

    assign match    = (bus.issue_instr_i & 32'h0600707F) == 32'h06000033;
    assign push     = bus.issue_valid_i && bus.issue_ready_o && match;
    assign push_hit = bus.commit_valid_i && (bus.commit_id_i == bus.issue_id_i);

    // Non-MAC instructions always complete the handshake (with accept=0).
    assign bus.issue_ready_o     = !match || ((count_q < CntW'(DEPTH)) && (&bus.issue_rs_valid_i));
    assign bus.issue_accept_o    = match;
    assign bus.issue_writeback_o = match;

    assign head_valid     = valid_q[head_q];
    assign head_committed = committed_q[head_q];
    assign head_killed    = killed_q[head_q];

    // Queue storage, commit/kill marking and pointer/count bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                id_q[i]  <= '0;
                rd_q[i]  <= '0;
                rs1_q[i] <= '0;
                rs2_q[i] <= '0;
                rs3_q[i] <= '0;
            end
            valid_q     <= '0;
            committed_q <= '0;
            killed_q    <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            if (bus.commit_valid_i) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (valid_q[i] && (id_q[i] == bus.commit_id_i)) begin
                        if (!bus.commit_kill_i) begin
                            committed_q[i] <= 1'b1;
                        end else if (!committed_q[i]) begin
                            killed_q[i] <= 1'b1;
                        end
                    end
                end
            end
            if (push) begin
                valid_q[tail_q]     <= 1'b1;
                id_q[tail_q]        <= bus.issue_id_i;
                rd_q[tail_q]        <= bus.issue_instr_i[11:7];
                rs1_q[tail_q]       <= bus.issue_rs_i[XLEN-1:0];
                rs2_q[tail_q]       <= bus.issue_rs_i[2*XLEN-1:XLEN];
                rs3_q[tail_q]       <= bus.issue_rs_i[3*XLEN-1:2*XLEN];
                // A commit naming the entry being pushed applies to it as well.
                committed_q[tail_q] <= push_hit && !bus.commit_kill_i;
                killed_q[tail_q]    <= push_hit && bus.commit_kill_i;
                tail_q              <= tail_q + 1'b1;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sequencer state and captured datapath result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Sequencer next state: run the head entry, drop it if killed, hold result until taken.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        pop     = 1'b0;
        start   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (head_valid) begin
                    if (head_killed) begin
                        pop = 1'b1;
                    end else if (head_committed) begin
                        start   = 1'b1;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (bus.mac_done_i) begin
                    if (head_killed) begin
                        pop     = 1'b1;
                        state_d = StIdle;
                    end else begin
                        data_d  = bus.mac_result_i;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (bus.result_ready_i) begin
                    pop     = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.mac_start_o    = start;
    assign bus.mac_rs1_o      = rs1_q[head_q];
    assign bus.mac_rs2_o      = rs2_q[head_q];
    assign bus.mac_rs3_o      = rs3_q[head_q];
    assign bus.result_valid_o = (state_q == StResp);
    assign bus.result_we_o    = (state_q == StResp);
    assign bus.result_id_o    = id_q[head_q];
    assign bus.result_rd_o    = rd_q[head_q];
    assign bus.result_data_o  = data_q;
endmodule

// File: tb/tb_cvxif_mac4b_ctrl.sv
// Bench for cvxif_mac4b_ctrl: directed scenarios followed by a randomized run, all
// checked every cycle against a transaction-level queue model and a behavioural datapath.
module tb_cvxif_mac4b_ctrl;
    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] rs3;
        bit          committed;
        bit          killed;
    } ent_t;

    logic clk;
    logic rst_n;

    cvxif_mac4b_ctrl_if #(.XLEN(32), .ID_WIDTH(4)) bus ();

    cvxif_mac4b_ctrl #(.XLEN(32), .ID_WIDTH(4), .DEPTH(DEPTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;
    ent_t        mq[$];
    bit          busy;
    bit          res_pend;
    logic [31:0] res_data;
    int          dp_cnt;
    logic [31:0] dp_res;
    int          lat_cfg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic bit is_mac(input logic [31:0] instr);
        return (instr & 32'h0600707F) == 32'h06000033;
    endfunction

    // Sum of four byte products plus accumulator.
    function automatic logic [31:0] mac_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
        logic [31:0] s;
        s = c;
        for (int k = 0; k < 4; k++) s = s + 32'(a[8*k +: 8]) * 32'(b[8*k +: 8]);
        return s;
    endfunction

    function automatic logic [31:0] mk_instr(input logic [4:0] rd);
        return 32'h06000033 | ($urandom() & 32'hF9FF8000) | (32'(rd) << 7);
    endfunction

    function automatic bit in_q(input logic [3:0] id);
        foreach (mq[i]) if (mq[i].id == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle();
        bus.issue_valid_i    = 1'b0;
        bus.issue_instr_i    = '0;
        bus.issue_id_i       = '0;
        bus.issue_rs_i       = '0;
        bus.issue_rs_valid_i = '0;
        bus.commit_valid_i   = 1'b0;
        bus.commit_id_i      = '0;
        bus.commit_kill_i    = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        busy     = 1'b0;
        res_pend = 1'b0;
    endtask

    // One clock cycle: drive the datapath, check outputs, advance the model across the edge.
    task automatic tick();
        bit          m, exp_ready, exp_start, iv, cv, ck, rdy, done;
        logic [3:0]  iid, cid;
        logic [31:0] ins, mres;
        logic [95:0] rs;
        ent_t        e;
        bus.mac_done_i   = 1'b0;
        bus.mac_result_i = $urandom();
        if (dp_cnt > 0) begin
            dp_cnt--;
            if (dp_cnt == 0) begin
                bus.mac_done_i   = 1'b1;
                bus.mac_result_i = dp_res;
            end
        end else if (!(busy && !res_pend) && $urandom_range(0, 7) == 0) begin
            bus.mac_done_i = 1'b1;  // stray done outside WAIT must be ignored
        end
        #1;
        m         = is_mac(bus.issue_instr_i);
        exp_ready = !m || (mq.size() < DEPTH && (&bus.issue_rs_valid_i));
        exp_start = !busy && mq.size() > 0 && mq[0].committed && !mq[0].killed;
        chk1("issue_ready", bus.issue_ready_o, exp_ready);
        chk1("issue_accept", bus.issue_accept_o, m);
        chk1("issue_writeback", bus.issue_writeback_o, m);
        chk1("mac_start", bus.mac_start_o, exp_start);
        if ((exp_start || (busy && !res_pend)) && mq.size() > 0) begin
            chk("mac_rs1", bus.mac_rs1_o, mq[0].rs1);
            chk("mac_rs2", bus.mac_rs2_o, mq[0].rs2);
            chk("mac_rs3", bus.mac_rs3_o, mq[0].rs3);
        end
        chk1("result_valid", bus.result_valid_o, res_pend);
        chk1("result_we", bus.result_we_o, res_pend);
        if (res_pend) begin
            chk("result_id", 32'(bus.result_id_o), 32'(mq[0].id));
            chk("result_rd", 32'(bus.result_rd_o), 32'(mq[0].rd));
            chk("result_data", bus.result_data_o, res_data);
        end
        if (bus.mac_start_o) begin
            dp_cnt = (lat_cfg != 0) ? lat_cfg : $urandom_range(1, 3);
            dp_res = (mq.size() > 0) ? mac_fn(mq[0].rs1, mq[0].rs2, mq[0].rs3) : 32'h0;
        end
        iv = bus.issue_valid_i;  iid = bus.issue_id_i;  ins = bus.issue_instr_i;
        rs = bus.issue_rs_i;     cv = bus.commit_valid_i; cid = bus.commit_id_i;
        ck = bus.commit_kill_i;  rdy = bus.result_ready_i; done = bus.mac_done_i;
        mres = bus.mac_result_i;
        @(posedge clk);
        if (!busy) begin
            if (mq.size() > 0 && mq[0].killed) void'(mq.pop_front());
            else if (exp_start) busy = 1'b1;
        end else if (!res_pend) begin
            if (done) begin
                if (mq[0].killed) begin
                    void'(mq.pop_front());
                    busy = 1'b0;
                end else begin
                    res_pend = 1'b1;
                    res_data = mres;
                end
            end
        end else if (rdy) begin
            void'(mq.pop_front());
            busy     = 1'b0;
            res_pend = 1'b0;
        end
        if (iv && exp_ready && m) begin
            e.id = iid; e.rd = ins[11:7];
            e.rs1 = rs[31:0]; e.rs2 = rs[63:32]; e.rs3 = rs[95:64];
            e.committed = 1'b0; e.killed = 1'b0;
            mq.push_back(e);
        end
        if (cv) begin
            foreach (mq[i]) begin
                if (mq[i].id == cid) begin
                    if (!ck) mq[i].committed = 1'b1;
                    else if (!mq[i].committed) mq[i].killed = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic issue(input logic [3:0] id, input logic [31:0] instr, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] r3);
        bus.issue_valid_i    = 1'b1;
        bus.issue_instr_i    = instr;
        bus.issue_id_i       = id;
        bus.issue_rs_i       = {r3, r2, r1};
        bus.issue_rs_valid_i = 3'b111;
        tick();
        bus.issue_valid_i = 1'b0;
    endtask

    task automatic issue_rand(input logic [3:0] id);
        issue(id, mk_instr(5'($urandom())), $urandom(), $urandom(), $urandom());
    endtask

    task automatic commit(input logic [3:0] id, input logic kill);
        bus.commit_valid_i = 1'b1;
        bus.commit_id_i    = id;
        bus.commit_kill_i  = kill;
        tick();
        bus.commit_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 80 && mq.size() > 0; n++) tick();
        chk1(tag, mq.size() == 0, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_ready"}, bus.issue_ready_o, 1'b1);
        chk1({tag, "_accept"}, bus.issue_accept_o, 1'b0);
        chk1({tag, "_writeback"}, bus.issue_writeback_o, 1'b0);
        chk1({tag, "_start"}, bus.mac_start_o, 1'b0);
        chk1({tag, "_valid"}, bus.result_valid_o, 1'b0);
        chk1({tag, "_we"}, bus.result_we_o, 1'b0);
        chk({tag, "_id"}, 32'(bus.result_id_o), 32'h0);
        chk({tag, "_rd"}, 32'(bus.result_rd_o), 32'h0);
        chk({tag, "_data"}, bus.result_data_o, 32'h0);
        chk({tag, "_rs"}, bus.mac_rs1_o | bus.mac_rs2_o | bus.mac_rs3_o, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        logic [31:0] cap;
        logic [3:0]  ids[$];
        bit          seen;
        vectors = 0; miscompares = 0; dp_cnt = 0; lat_cfg = 0;
        model_reset();
        idle();
        bus.mac_done_i     = 1'b0;
        bus.mac_result_i   = '0;
        bus.result_ready_i = 1'b1;
        rst_n = 1'b0;
        #2 check_reset_outputs("por");
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single instruction with fixed 2-cycle datapath latency.
        lat_cfg = 2;
        bus.issue_valid_i = 1'b1; bus.issue_instr_i = 32'h06208533; bus.issue_id_i = 4'd3;
        bus.issue_rs_i = {32'h0, 32'h01010101, 32'h01020304}; bus.issue_rs_valid_i = 3'b111;
        #1;
        chk1("single_accept", bus.issue_accept_o, 1'b1);
        tick();
        idle();
        commit(4'd3, 1'b0);
        #1 chk1("single_start", bus.mac_start_o, 1'b1);
        tick(); tick(); tick();
        #1;
        chk1("single_valid", bus.result_valid_o, 1'b1);
        chk("single_id", 32'(bus.result_id_o), 32'd3);
        chk("single_rd", 32'(bus.result_rd_o), 32'd10);
        chk("single_data", bus.result_data_o, 32'h0000000A);
        tick();

        // Non-MAC instruction completes immediately without queuing.
        bus.issue_valid_i = 1'b1; bus.issue_instr_i = 32'h00208533; bus.issue_id_i = 4'd5;
        bus.issue_rs_valid_i = 3'b000;
        #1;
        chk1("alu_ready", bus.issue_ready_o, 1'b1);
        chk1("alu_accept", bus.issue_accept_o, 1'b0);
        chk1("alu_writeback", bus.issue_writeback_o, 1'b0);
        tick();
        idle();
        chk1("alu_no_push", mq.size() == 0, 1'b1);

        // Queue full: 5th issue stalls until the first result handshake frees an entry.
        lat_cfg = 0;
        for (int i = 4; i < 8; i++) issue_rand(4'(i));
        bus.issue_valid_i = 1'b1; bus.issue_instr_i = mk_instr(5'd7); bus.issue_id_i = 4'd8;
        bus.issue_rs_i = {3{$urandom()}}; bus.issue_rs_valid_i = 3'b111;
        #1 chk1("full_ready", bus.issue_ready_o, 1'b0);
        tick();
        for (int i = 4; i < 8; i++) commit(4'(i), 1'b0);
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            seen = bus.issue_ready_o;
            tick();
        end
        chk1("full_unblock", seen, 1'b1);
        idle();
        commit(4'd8, 1'b0);
        drain("full_drain");

        // Kill at head while idle: popped without starting.
        issue_rand(4'd9);
        commit(4'd9, 1'b1);
        #1 chk1("kill_idle_nostart", bus.mac_start_o, 1'b0);
        tick();
        issue_rand(4'd10);
        commit(4'd10, 1'b0);
        drain("kill_idle_drain");

        // Kills while in WAIT: committed head is unaffected, the queued one is dropped.
        lat_cfg = 3;
        issue_rand(4'd11);
        issue_rand(4'd12);
        commit(4'd11, 1'b0);
        tick();
        commit(4'd11, 1'b1);
        commit(4'd12, 1'b1);
        tick();
        #1 chk1("kill_wait_valid", bus.result_valid_o, 1'b1);
        chk("kill_wait_id", 32'(bus.result_id_o), 32'd11);
        drain("kill_wait_drain");

        // Backpressure and ordering.
        lat_cfg = 0;
        issue_rand(4'd1);
        issue_rand(4'd2);
        commit(4'd1, 1'b0);
        commit(4'd2, 1'b0);
        bus.result_ready_i = 1'b0;
        for (int n = 0; n < 20 && !bus.result_valid_o; n++) tick();
        chk1("bp_valid", bus.result_valid_o, 1'b1);
        cap = bus.result_data_o;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("bp_data_stable", bus.result_data_o, cap);
            chk("bp_id", 32'(bus.result_id_o), 32'd1);
        end
        bus.result_ready_i = 1'b1;
        drain("bp_drain");

        // Asynchronous reset while waiting on the datapath.
        lat_cfg = 3;
        issue_rand(4'd13);
        commit(4'd13, 1'b0);
        tick();
        tick();
        idle();
        bus.mac_done_i = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("arst");
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 6; n++) tick();
        for (int i = 1; i < 5; i++) issue_rand(4'(i));
        bus.issue_valid_i = 1'b1; bus.issue_instr_i = mk_instr(5'd1); bus.issue_id_i = 4'd9;
        bus.issue_rs_valid_i = 3'b111;
        #1 chk1("arst_empty_full", bus.issue_ready_o, 1'b0);
        idle();
        for (int i = 1; i < 5; i++) commit(4'(i), 1'b0);
        drain("arst_drain");

        // Randomized traffic.
        lat_cfg = 0;
        for (int c = 0; c < 700; c++) begin
            logic [3:0] nid;
            idle();
            bus.result_ready_i = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 6) begin
                nid = 4'($urandom());
                while (in_q(nid)) nid = nid + 4'd1;
                bus.issue_valid_i    = 1'b1;
                bus.issue_instr_i    = ($urandom_range(0, 4) == 0) ? $urandom()
                                                                   : mk_instr(5'($urandom()));
                bus.issue_id_i       = nid;
                bus.issue_rs_i       = {$urandom(), $urandom(), $urandom()};
                bus.issue_rs_valid_i = ($urandom_range(0, 7) == 0) ? 3'($urandom()) : 3'b111;
            end
            if ($urandom_range(0, 9) < 4) begin
                bus.commit_valid_i = 1'b1;
                bus.commit_kill_i  = ($urandom_range(0, 3) == 0);
                if (mq.size() > 0 && $urandom_range(0, 9) < 7)
                    bus.commit_id_i = mq[$urandom_range(0, mq.size() - 1)].id;
                else if (bus.issue_valid_i && $urandom_range(0, 1) == 1)
                    bus.commit_id_i = bus.issue_id_i;
                else
                    bus.commit_id_i = 4'($urandom());
            end
            tick();
        end
        idle();
        bus.result_ready_i = 1'b1;
        foreach (mq[i]) ids.push_back(mq[i].id);
        foreach (ids[i]) commit(ids[i], 1'b0);
        drain("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
